// File: rtl/irq_seq.sv
`default_nettype none
//==============================================================================
// irq_seq : interrupt entry/exit sequencer between the VIC and the uC core
// Rev 1.0
//==============================================================================
module irq_seq #(
    parameter int MAX_NEST = 4,
    parameter int HOLDOFF  = 3
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            irq_i,
    input  logic [15:0]                     irqaddr_i,
    output logic                            irqack_o,
    input  logic                            boundary_i,
    input  logic [15:0]                     pc_i,
    input  logic                            ei_i,
    input  logic                            di_i,
    input  logic                            reti_i,
    output logic                            hold_o,
    output logic                            jump_o,
    output logic [15:0]                     jump_addr_o,
    output logic                            push_o,
    output logic [16:0]                     push_data_o,
    input  logic                            push_ready_i,
    output logic                            pop_o,
    input  logic [16:0]                     pop_data_i,
    input  logic                            pop_valid_i,
    output logic                            gie_o,
    output logic [$clog2(MAX_NEST+1)-1:0]   nest_o,
    output logic                            err_o
);

    localparam int NW = $clog2(MAX_NEST + 1);
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_ACK     = 3'd2,
        S_PUSH    = 3'd3,
        S_JUMP    = 3'd4,
        S_POP     = 3'd5,
        S_RESUME  = 3'd6
    } state_t;

    state_t          state_q;
    logic [15:0]     vector_q;
    logic [15:0]     pc_q;
    logic            sgie_q;
    logic            rgie_q;
    logic            gie_q;
    logic [NW-1:0]   nest_q;
    logic            err_q;
    logic [HW-1:0]   holdoff_q;
    logic [HW-1:0]   holdoff_d;
    logic            irqack_q;
    logic            push_q;
    logic [16:0]     push_data_q;
    logic            pop_q;
    logic            jump_q;
    logic [15:0]     jump_addr_q;

    logic            w_idle;
    logic            w_nest_nz;
    logic            w_take;

    assign w_idle    = (state_q == S_IDLE);
    assign w_nest_nz = (nest_q != '0);
    assign w_take    = w_idle & irq_i & gie_q & boundary_i
                     & (nest_q < NW'(MAX_NEST)) & (holdoff_q == '0) & ~reti_i;

    // Combinational so the core freezes in the very cycle the decision is made.
    assign hold_o      = ~w_idle | w_take | (w_idle & reti_i & w_nest_nz);

    assign irqack_o    = irqack_q;
    assign push_o      = push_q;
    assign push_data_o = push_data_q;
    assign pop_o       = pop_q;
    assign jump_o      = jump_q;
    assign jump_addr_o = jump_addr_q;
    assign gie_o       = gie_q;
    assign nest_o      = nest_q;
    assign err_o       = err_q;

    // Masks the VIC request while the acknowledged index propagates to its mask.
    always_comb begin
        holdoff_d = holdoff_q;
        if (state_q == S_ACK) begin
            holdoff_d = HW'(HOLDOFF);
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            holdoff_q <= '0;
        end else begin
            holdoff_q <= holdoff_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            vector_q    <= '0;
            pc_q        <= '0;
            sgie_q      <= 1'b0;
            rgie_q      <= 1'b0;
            gie_q       <= 1'b0;
            nest_q      <= '0;
            err_q       <= 1'b0;
            irqack_q    <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            pop_q       <= 1'b0;
            jump_q      <= 1'b0;
            jump_addr_q <= '0;
        end else begin
            irqack_q    <= 1'b0;
            jump_q      <= 1'b0;
            jump_addr_q <= '0;
            case (state_q)
                S_IDLE: begin
                    // Return has priority over a new entry in the same cycle.
                    if (reti_i) begin
                        if (w_nest_nz) begin
                            state_q <= S_POP;
                            pop_q   <= 1'b1;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end else if (w_take) begin
                        state_q  <= S_CAPTURE;
                        vector_q <= irqaddr_i;
                        pc_q     <= pc_i;
                        sgie_q   <= gie_q;
                        gie_q    <= 1'b0;
                    end else if (di_i) begin
                        gie_q <= 1'b0;
                    end else if (ei_i) begin
                        gie_q <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    state_q  <= S_ACK;
                    irqack_q <= 1'b1;
                end
                S_ACK: begin
                    state_q     <= S_PUSH;
                    push_q      <= 1'b1;
                    push_data_q <= {sgie_q, pc_q};
                end
                S_PUSH: begin
                    if (push_ready_i) begin
                        state_q     <= S_JUMP;
                        push_q      <= 1'b0;
                        push_data_q <= '0;
                        jump_q      <= 1'b1;
                        jump_addr_q <= vector_q;
                    end
                end
                S_JUMP: begin
                    state_q <= S_IDLE;
                    nest_q  <= nest_q + 1'b1;
                end
                S_POP: begin
                    if (pop_valid_i) begin
                        state_q     <= S_RESUME;
                        pop_q       <= 1'b0;
                        rgie_q      <= pop_data_i[16];
                        jump_q      <= 1'b1;
                        jump_addr_q <= pop_data_i[15:0];
                    end
                end
                S_RESUME: begin
                    state_q <= S_IDLE;
                    gie_q   <= rgie_q;
                    if (w_nest_nz) begin
                        nest_q <= nest_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_seq.sv
`default_nettype none
//==============================================================================
// tb_irq_seq : vector table, directed corner sequences and random run vs model
// Rev 1.0
//==============================================================================
module tb_irq_seq;

    localparam int MAX_NEST = 4;
    localparam int HOLDOFF  = 3;

    logic        clk_i, rstn_i;
    logic        irq_i, boundary_i, ei_i, di_i, reti_i, push_ready_i, pop_valid_i;
    logic [15:0] irqaddr_i, pc_i;
    logic [16:0] pop_data_i;
    logic        irqack_o, hold_o, jump_o, push_o, pop_o, gie_o, err_o;
    logic [15:0] jump_addr_o;
    logic [16:0] push_data_o;
    logic [2:0]  nest_o;

    irq_seq #(.MAX_NEST(MAX_NEST), .HOLDOFF(HOLDOFF)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .irq_i(irq_i), .irqaddr_i(irqaddr_i), .irqack_o(irqack_o),
        .boundary_i(boundary_i), .pc_i(pc_i),
        .ei_i(ei_i), .di_i(di_i), .reti_i(reti_i),
        .hold_o(hold_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o),
        .push_o(push_o), .push_data_o(push_data_o), .push_ready_i(push_ready_i),
        .pop_o(pop_o), .pop_data_i(pop_data_i), .pop_valid_i(pop_valid_i),
        .gie_o(gie_o), .nest_o(nest_o), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: interrupt context as "age since decision" plus a handshake flag.
    bit          m_gie, m_err, m_sgie, m_rgie, m_epushed, m_xpopped;
    int          m_nest, m_hold, m_eage, m_xage;
    logic [15:0] m_vec, m_pc, m_raddr;
    logic [16:0] stk[$];

    typedef struct {
        logic irq; logic [15:0] addr; logic bnd; logic [15:0] pc;
        logic ei, di, reti, pr, pv;
        logic x_hold, x_ack, x_push; logic [16:0] x_pdata;
        logic x_jump; logic [15:0] x_jaddr; logic x_pop, x_gie; int x_nest;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_gie = 0; m_err = 0; m_sgie = 0; m_rgie = 0; m_epushed = 0; m_xpopped = 0;
        m_nest = 0; m_hold = 0; m_eage = 0; m_xage = 0;
        m_vec = '0; m_pc = '0; m_raddr = '0;
        stk.delete();
    endtask

    task automatic step(input logic irq, input logic [15:0] addr, input logic bnd,
                        input logic [15:0] pc, input logic ei, input logic di,
                        input logic reti, input logic pr, input logic pv);
        bit          idle, take, e_hold, e_ack, e_push, e_jump, e_pop;
        logic [16:0] e_pdata;
        logic [15:0] e_jaddr;
        @(negedge clk_i);
        irq_i = irq; irqaddr_i = addr; boundary_i = bnd; pc_i = pc;
        ei_i = ei; di_i = di; reti_i = reti; push_ready_i = pr; pop_valid_i = pv;
        pop_data_i = (stk.size() > 0) ? stk[stk.size()-1] : 17'($urandom);
        #1;
        idle    = (m_eage == 0) && (m_xage == 0);
        take    = idle && irq && m_gie && bnd && (m_nest < MAX_NEST) && (m_hold == 0) && !reti;
        e_hold  = !idle || take || (idle && reti && m_nest > 0);
        e_ack   = (m_eage == 2);
        e_push  = (m_eage >= 3) && !m_epushed;
        e_pdata = e_push ? {m_sgie, m_pc} : 17'h0;
        e_pop   = (m_xage >= 1) && !m_xpopped;
        e_jump  = m_epushed || m_xpopped;
        e_jaddr = m_epushed ? m_vec : (m_xpopped ? m_raddr : 16'h0);
        chk("hold", hold_o, e_hold);
        chk("irqack", irqack_o, e_ack);
        chk("push", push_o, e_push);
        chk("push_data", push_data_o, e_pdata);
        chk("pop", pop_o, e_pop);
        chk("jump", jump_o, e_jump);
        chk("jump_addr", jump_addr_o, e_jaddr);
        chk("gie", gie_o, m_gie);
        chk("nest", nest_o, m_nest);
        chk("err", err_o, m_err);
        // advance the model to the state after the coming clock edge
        if (m_eage == 2) m_hold = HOLDOFF;
        else if (m_hold > 0) m_hold--;
        if (idle) begin
            if (reti) begin
                if (m_nest > 0) m_xage = 1;
                else m_err = 1;
            end else if (take) begin
                m_eage = 1; m_vec = addr; m_pc = pc; m_sgie = m_gie; m_gie = 0;
            end else if (di) m_gie = 0;
            else if (ei) m_gie = 1;
        end else if (m_eage > 0) begin
            if (m_epushed) begin
                m_nest++; m_eage = 0; m_epushed = 0;
            end else begin
                if (e_push && pr) begin
                    m_epushed = 1;
                    stk.push_back({m_sgie, m_pc});
                end
                m_eage++;
            end
        end else begin
            if (m_xpopped) begin
                m_gie = m_rgie; m_nest--; m_xage = 0; m_xpopped = 0;
            end else begin
                if (e_pop && pv) begin
                    m_xpopped = 1; m_rgie = pop_data_i[16]; m_raddr = pop_data_i[15:0];
                    if (stk.size() > 0) void'(stk.pop_back());
                end
                m_xage++;
            end
        end
    endtask

    task automatic idle_c(input logic pr, input logic pv);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, pr, pv);
    endtask

    task automatic ei_c();
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter(input logic [15:0] addr, input logic [15:0] pc);
        step(1'b1, addr, 1'b1, pc, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) idle_c(1'b1, 1'b0);
    endtask

    task automatic leave();
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_c(1'b0, 1'b1);
        idle_c(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        irq_i = 0; boundary_i = 0; ei_i = 0; di_i = 0; reti_i = 0;
        push_ready_i = 0; pop_valid_i = 0;
        #2 rstn_i = 1'b0;
        #1;
        chk("rst.hold", hold_o, 0);   chk("rst.irqack", irqack_o, 0);
        chk("rst.push", push_o, 0);   chk("rst.push_data", push_data_o, 0);
        chk("rst.pop", pop_o, 0);     chk("rst.jump", jump_o, 0);
        chk("rst.jump_addr", jump_addr_o, 0);
        chk("rst.gie", gie_o, 0);     chk("rst.nest", nest_o, 0);
        chk("rst.err", err_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        model_reset();
    endtask

    function automatic vec_t mk(input logic irq, input logic [15:0] addr, input logic bnd,
                                input logic [15:0] pc, input logic ei, input logic reti,
                                input logic pr, input logic pv,
                                input logic h, input logic a, input logic p,
                                input logic [16:0] pd, input logic j, input logic [15:0] ja,
                                input logic po, input logic g, input int n);
        vec_t v;
        v.irq = irq; v.addr = addr; v.bnd = bnd; v.pc = pc; v.ei = ei; v.di = 1'b0;
        v.reti = reti; v.pr = pr; v.pv = pv;
        v.x_hold = h; v.x_ack = a; v.x_push = p; v.x_pdata = pd; v.x_jump = j;
        v.x_jaddr = ja; v.x_pop = po; v.x_gie = g; v.x_nest = n;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rstn_i = 1'b0;
        irq_i = 0; irqaddr_i = 0; boundary_i = 0; pc_i = 0; ei_i = 0; di_i = 0;
        reti_i = 0; push_ready_i = 0; pop_valid_i = 0; pop_data_i = 0;
        model_reset();

        // entry to 0x0120 from pc 0x0456, then reti with pop data two cycles late
        tbl[0]  = mk(0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0,  0, 0, 0, 17'h0,     0, 16'h0,    0, 0, 0);
        tbl[1]  = mk(1, 16'h0120, 1, 16'h0456, 0, 0, 1, 0,  1, 0, 0, 17'h0,     0, 16'h0,    0, 1, 0);
        tbl[2]  = mk(1, 16'h0120, 1, 16'h0456, 0, 0, 1, 0,  1, 0, 0, 17'h0,     0, 16'h0,    0, 0, 0);
        tbl[3]  = mk(1, 16'h0120, 1, 16'h0456, 0, 0, 1, 0,  1, 1, 0, 17'h0,     0, 16'h0,    0, 0, 0);
        tbl[4]  = mk(1, 16'h0120, 1, 16'h0456, 0, 0, 1, 0,  1, 0, 1, 17'h10456, 0, 16'h0,    0, 0, 0);
        tbl[5]  = mk(1, 16'h0120, 1, 16'h0456, 0, 0, 1, 0,  1, 0, 0, 17'h0,     1, 16'h0120, 0, 0, 0);
        tbl[6]  = mk(1, 16'h0120, 1, 16'h0456, 0, 0, 0, 0,  0, 0, 0, 17'h0,     0, 16'h0,    0, 0, 1);
        tbl[7]  = mk(0, 16'h0000, 0, 16'h0000, 0, 1, 0, 0,  1, 0, 0, 17'h0,     0, 16'h0,    0, 0, 1);
        tbl[8]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0,  1, 0, 0, 17'h0,     0, 16'h0,    1, 0, 1);
        tbl[9]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0,  1, 0, 0, 17'h0,     0, 16'h0,    1, 0, 1);
        tbl[10] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 1,  1, 0, 0, 17'h0,     0, 16'h0,    1, 0, 1);
        tbl[11] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0,  1, 0, 0, 17'h0,     1, 16'h0456, 0, 0, 1);
        tbl[12] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0,  0, 0, 0, 17'h0,     0, 16'h0,    0, 1, 0);

        repeat (2) @(negedge clk_i);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].irq, tbl[i].addr, tbl[i].bnd, tbl[i].pc, tbl[i].ei, tbl[i].di,
                 tbl[i].reti, tbl[i].pr, tbl[i].pv);
            chk($sformatf("tbl%0d.hold", i), hold_o, tbl[i].x_hold);
            chk($sformatf("tbl%0d.irqack", i), irqack_o, tbl[i].x_ack);
            chk($sformatf("tbl%0d.push", i), push_o, tbl[i].x_push);
            chk($sformatf("tbl%0d.push_data", i), push_data_o, tbl[i].x_pdata);
            chk($sformatf("tbl%0d.jump", i), jump_o, tbl[i].x_jump);
            chk($sformatf("tbl%0d.jump_addr", i), jump_addr_o, tbl[i].x_jaddr);
            chk($sformatf("tbl%0d.pop", i), pop_o, tbl[i].x_pop);
            chk($sformatf("tbl%0d.gie", i), gie_o, tbl[i].x_gie);
            chk($sformatf("tbl%0d.nest", i), nest_o, tbl[i].x_nest);
        end

        // reti and a takeable request in the same cycle: return wins, entry after resume
        enter(16'h0300, 16'h0111);
        ei_c();
        step(1'b1, 16'h0700, 1'b1, 16'h0222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("prio.hold", hold_o, 1);
        step(1'b1, 16'h0700, 1'b1, 16'h0222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("prio.pop", pop_o, 1);
        step(1'b1, 16'h0700, 1'b1, 16'h0222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("prio.resume_addr", jump_addr_o, 16'h0111);
        step(1'b1, 16'h0700, 1'b1, 16'h0222, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("prio.take_after", hold_o, 1);
        repeat (4) idle_c(1'b1, 1'b0);
        leave();

        // fill to MAX_NEST, fifth request must stay pending
        for (int k = 0; k < MAX_NEST; k++) begin
            ei_c();
            enter(16'h1000 + 16'(k), 16'h2000 + 16'(k));
        end
        ei_c();
        step(1'b1, 16'h0500, 1'b1, 16'h0555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full.hold", hold_o, 0);
        step(1'b1, 16'h0500, 1'b1, 16'h0555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0500, 1'b1, 16'h0555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full.no_ack", irqack_o, 0);
        chk("full.nest", nest_o, MAX_NEST);
        for (int k = 0; k < MAX_NEST; k++) leave();

        // reti with nothing to return to
        do_reset();
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("err.hold", hold_o, 0);
        idle_c(1'b0, 1'b0);
        chk("err.sticky", err_o, 1);
        chk("err.no_pop", pop_o, 0);

        // stalled push, then reset in the middle of it
        ei_c();
        step(1'b1, 16'h0abc, 1'b1, 16'h0def, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_c(1'b0, 1'b0);
        idle_c(1'b0, 1'b0);
        repeat (5) begin
            idle_c(1'b0, 1'b0);
            chk("stall.push_data", push_data_o, 17'h10def);
        end
        do_reset();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(99) < 50, 16'($urandom), $urandom_range(99) < 70,
                 16'($urandom), $urandom_range(99) < 25, $urandom_range(99) < 5,
                 $urandom_range(99) < 6, $urandom_range(99) < 50, $urandom_range(99) < 40);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_seq.md
Name: irq_seq

Overview:
- Interrupt entry/exit sequencer between the vectored interrupt controller (VIC) and the uC core.
- Decides when a pending VIC request is taken: global enable, instruction boundary, nesting depth.
- Runs the VIC acknowledge handshake and saves/restores {GIE, return PC} via a stack push/pop interface.
- Redirects core fetch to the handler vector, or to the popped return address on reti.

Parameters:
- MAX_NEST, 4: maximum nesting depth. No entry while nest count equals MAX_NEST.
- HOLDOFF, 3: cycles after irqack_o during which irq_i is ignored. Covers the VIC mask-to-irq propagation of 2 cycles plus 1 cycle of margin.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- irq_i  in  1  VIC request
- irqaddr_i  in  16  VIC vector; valid while irq_i=1
- irqack_o  out  1  VIC acknowledge, 1-cycle pulse
- boundary_i  in  1  core is at an instruction boundary
- pc_i  in  16  return address; valid with boundary_i
- ei_i  in  1  enable-interrupts strobe
- di_i  in  1  disable-interrupts strobe
- reti_i  in  1  return-from-interrupt strobe
- hold_o  out  1  core must not advance
- jump_o  out  1  redirect fetch, 1-cycle pulse
- jump_addr_o  out  16  fetch target; valid with jump_o
- push_o  out  1  stack push request
- push_data_o  out  17  {gie, return pc}
- push_ready_i  in  1  push accepted this cycle
- pop_o  out  1  stack pop request
- pop_data_i  in  17  {gie, return pc}
- pop_valid_i  in  1  pop data valid this cycle
- gie_o  out  1  global interrupt enable
- nest_o  out  clog2(MAX_NEST+1)  current nesting depth
- err_o  out  1  sticky: reti_i received with nest=0

Behaviour:
- Reset: state IDLE; all outputs 0; gie=0, nest=0, holdoff=0, err=0. Reset mid-sequence aborts to IDLE and discards latched vector/PC.

States: IDLE, CAPTURE, ACK, PUSH, JUMP, POP, RESUME.

Entry condition (evaluated in IDLE only): take = irq_i & gie & boundary_i & (nest<MAX_NEST) & (holdoff==0) & ~reti_i.

Transitions:
- IDLE, reti_i=1, nest>0 -> POP. reti_i has priority over take in the same cycle.
- IDLE, reti_i=1, nest=0 -> set err, stay IDLE.
- IDLE, take=1 -> CAPTURE. Latch vector_q<=irqaddr_i, pc_q<=pc_i, sgie_q<=gie. Clear gie.
- CAPTURE -> ACK. irqack_o is registered and high for exactly the ACK cycle, one cycle after the vector is sampled. This lines up with the VIC masking the index it presented at sampling time.
- ACK -> PUSH. Load holdoff=HOLDOFF.
- PUSH: push_o=1, push_data_o={sgie_q, pc_q}. Stay until push_ready_i=1, then -> JUMP.
- JUMP: jump_o=1, jump_addr_o=vector_q. nest+1. -> IDLE.
- POP: pop_o=1. Stay until pop_valid_i=1, then capture pop_data_i -> RESUME.
- RESUME: jump_o=1, jump_addr_o=popped[15:0], gie<=popped[16], nest-1. -> IDLE.

Other rules:
- hold_o = (state!=IDLE) | take | (IDLE & reti_i & nest>0). This is combinational, so the core freezes in the decision cycle.
- holdoff decrements by 1 each cycle while nonzero, in any state. It saturates at 0.
- ei_i/di_i act only in IDLE and only when take=0 and reti_i=0; otherwise they are ignored. ei_i sets gie, di_i clears it; if both are high, di_i wins. gie updates the cycle after the strobe.
- push_o and pop_o hold steady until their handshake completes. Outputs are unaffected by irq_i while in PUSH or POP.
- jump_addr_o is 0 whenever jump_o=0.
- nest never wraps: entry is blocked at MAX_NEST, and decrement occurs only when nest>0.

Test Plan:
- gie=1, nest=0, irq_i=1, irqaddr_i=0x0120, boundary_i=1, pc_i=0x0456, push_ready_i=1 -> irqack_o high at cycle +2; push_data_o=0x10456 at cycle +3; jump_o with 0x0120 at cycle +4; nest_o=1, gie_o=0.
- Keep irq_i=1 for 3 cycles after ack with gie re-enabled via ei_i -> no second entry until holdoff expires.
- In handler, reti_i=1, pop_valid_i after 2 cycles with 0x10456 -> pop_o held 3 cycles; jump_o with 0x0456; gie_o=1; nest_o=0.
- reti_i and take in the same cycle with nest=1 -> POP path taken; irq entered only after RESUME.
- Nested entries with MAX_NEST=4 -> 5th request stays pending (hold_o=0, no irqack_o) until a reti. Separately, reti_i at nest=0 -> err_o=1, no pop_o.
- push_ready_i low for 5 cycles -> push_o and push_data_o stable, hold_o=1. Then rstn_i pulse mid-PUSH -> all outputs 0, state IDLE.
